// File: rtl/sp1_rrmux_pkg.sv
// sp1_rrmux_pkg: arbitration mode constants and elaboration/encoding helpers shared by the rrmux slice.
package sp1_rrmux_pkg;
  localparam int SP1_ARB_RR  = 0;
  localparam int SP1_ARB_FIX = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = r | (3'(i) & {3{oh[i]}});
    return r;
  endfunction
endpackage

// File: rtl/sp1_rrarb.sv
// sp1_rrarb: one-hot round-robin / fixed-priority grant over req, owning the wrap-modulo-N pointer.
module sp1_rrarb
  import sp1_rrmux_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = SP1_ARB_RR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] grant
);
  localparam int SW = clog2(N);
  logic [SW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  rot, rot_g;
  logic [2:0]    gi;
  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot   = N'({req, req} >> ptr_q);
    rot_g = rot & (~rot + N'(1));
    grant = N'(({rot_g, rot_g} << ptr_q) >> N);
    gi    = oh2idx(8'(grant));
    ptr_d = (MODE == SP1_ARB_FIX) ? '0 : !adv ? ptr_q : (gi == 3'(N - 1)) ? '0 : SW'(gi + 3'd1);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/sp1_rrmux.sv
// sp1_rrmux: registered N-channel arbitrating mux with valid/ready on every channel and on the output.
module sp1_rrmux
  import sp1_rrmux_pkg::*;
#(
  parameter int DW   = 8,
  parameter int N    = 4,
  parameter int SW   = 2,
  parameter int MODE = SP1_ARB_RR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [SW-1:0]   out_ch,
  input  logic            out_ready
);
  if (SW != clog2(N)) begin : g_sw_chk
    $error("sp1_rrmux: SW=%0d does not match clog2(N)=%0d", SW, clog2(N));
  end
  logic [N-1:0]  grant;
  logic          take, xfer;
  logic [DW-1:0] mux;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  sp1_rrarb #(.N(N), .MODE(MODE)) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (in_valid),
    .adv  (xfer),
    .grant(grant)
  );
  // Ready is masked by rst so nothing is offered while the block is held in reset.
  always_comb begin
    take     = !out_valid_q || out_ready;
    in_ready = grant & {N{take && rst}};
    xfer     = |in_ready;
    mux      = '0;
    for (int i = 0; i < N; i++) mux = mux | (in_data[i*DW +: DW] & {DW{grant[i]}});
    out_valid_d = xfer ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    out_data_d  = xfer ? mux : out_data_q;
    out_ch_d    = xfer ? SW'(oh2idx(8'(grant))) : out_ch_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
endmodule

// File: tb/tb_sp1_rrmux.sv
// tb_sp1_rrmux: round-robin N=4, fixed-priority N=4 and round-robin N=3 instances against a channel-level reference model.
module tb_sp1_rrmux;
  import sp1_rrmux_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic [3:0]  iv[3];
  logic [31:0] id[3];
  logic        ordy[3];
  logic [3:0]  rr_rdy, fx_rdy;
  logic [2:0]  n3_rdy;
  logic        rr_ov, fx_ov, n3_ov;
  logic [7:0]  rr_od, fx_od, n3_od;
  logic [1:0]  rr_ch, fx_ch, n3_ch;
  sp1_rrmux #(.DW(8), .N(4), .SW(2), .MODE(SP1_ARB_RR)) u_rr (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id[0]), .in_ready(rr_rdy),
    .out_valid(rr_ov), .out_data(rr_od), .out_ch(rr_ch), .out_ready(ordy[0]));
  sp1_rrmux #(.DW(8), .N(4), .SW(2), .MODE(SP1_ARB_FIX)) u_fx (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id[1]), .in_ready(fx_rdy),
    .out_valid(fx_ov), .out_data(fx_od), .out_ch(fx_ch), .out_ready(ordy[1]));
  sp1_rrmux #(.DW(8), .N(3), .SW(2), .MODE(SP1_ARB_RR)) u_n3 (
    .clk(clk), .rst(rst), .in_valid(iv[2][2:0]), .in_data(id[2][23:0]), .in_ready(n3_rdy),
    .out_valid(n3_ov), .out_data(n3_od), .out_ch(n3_ch), .out_ready(ordy[2]));
  int nn[3] = '{4, 4, 3};
  int md[3] = '{0, 1, 0};
  int m_ptr[3], m_och[3];
  logic m_ov[3];
  logic [7:0] m_od[3];
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ptr[i] = 0;
      m_och[i] = 0;
      m_ov[i]  = 1'b0;
      m_od[i]  = 8'h00;
    end
  endtask
  // Winner: first valid channel scanning upward from the pointer (or from 0 in fixed mode), wrapping mod N.
  function automatic int pick(input int i);
    int s, c;
    s = (md[i] == 1) ? 0 : m_ptr[i];
    for (int k = 0; k < nn[i]; k++) begin
      c = (s + k) % nn[i];
      if (iv[i][c[1:0]]) return c;
    end
    return -1;
  endfunction
  task automatic step();
    logic [3:0] grdy[3];
    logic       gov[3];
    logic [7:0] god[3];
    logic [1:0] gch[3];
    int         xg[3];
    int         g;
    logic       take;
    logic [3:0] erdy;
    @(negedge clk);
    grdy = '{rr_rdy, fx_rdy, {1'b0, n3_rdy}};
    gov  = '{rr_ov, fx_ov, n3_ov};
    god  = '{rr_od, fx_od, n3_od};
    gch  = '{rr_ch, fx_ch, n3_ch};
    for (int i = 0; i < 3; i++) begin
      g     = pick(i);
      take  = !m_ov[i] || ordy[i];
      erdy  = (rst && take && g >= 0) ? 4'(1 << g) : 4'h0;
      xg[i] = (rst && take) ? g : -1;
      chk($sformatf("in_ready[u%0d]", i), 32'(grdy[i]), 32'(erdy));
      chk($sformatf("out_valid[u%0d]", i), 32'(gov[i]), 32'(m_ov[i]));
      chk($sformatf("out_data[u%0d]", i), 32'(god[i]), 32'(m_od[i]));
      chk($sformatf("out_ch[u%0d]", i), 32'(gch[i]), 32'(m_och[i]));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_ptr[i] = 0; m_och[i] = 0; m_ov[i] = 1'b0; m_od[i] = 8'h00;
      end else if (xg[i] >= 0) begin
        m_ov[i]  = 1'b1;
        m_od[i]  = 8'(id[i] >> (8 * xg[i]));
        m_och[i] = xg[i];
        if (md[i] == 0) m_ptr[i] = (xg[i] + 1) % nn[i];
      end else if (ordy[i]) m_ov[i] = 1'b0;
    end
  endtask
  // Reset asserted mid-cycle must clear the output and all readies without waiting for a clock edge.
  task automatic async_rst();
    #2 rst = 1'b0;
    #1;
    chk("async out_valid[u0]", 32'(rr_ov), 32'd0);
    chk("async out_valid[u1]", 32'(fx_ov), 32'd0);
    chk("async out_valid[u2]", 32'(n3_ov), 32'd0);
    chk("async in_ready", 32'({rr_rdy, fx_rdy, n3_rdy}), 32'd0);
    model_reset();
    repeat (2) step();
    rst = 1'b1;
  endtask
  initial begin
    model_reset();
    iv   = '{4'hf, 4'hf, 4'h7};
    ordy = '{1'b1, 1'b1, 1'b1};
    id   = '{32'h43322110, 32'h43322110, 32'h00322110};
    repeat (3) step();
    rst = 1'b1;
    iv  = '{4'hf, 4'h9, 4'h7};
    repeat (7) step();
    iv[0] = 4'b0110;
    repeat (3) step();
    iv = '{4'hf, 4'h9, 4'h7};
    step();
    ordy = '{1'b0, 1'b0, 1'b0};
    repeat (6) step();
    ordy = '{1'b1, 1'b1, 1'b1};
    repeat (3) step();
    iv[1] = 4'h8;
    repeat (3) step();
    iv[1] = 4'h9;
    repeat (4) step();
    async_rst();
    repeat (5) step();
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < 3; i++) begin
        iv[i]   = (i == 2) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
        id[i]   = $urandom;
        ordy[i] = ($urandom_range(0, 3) != 0);
      end
      step();
      if ($urandom_range(0, 39) == 0) async_rst();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
